// File: rtl/wlb_pkg.sv
// wlb_pkg: shared FSM state, dimension-width derivation and tap-index helpers for window_line_buffer
package wlb_pkg;

   typedef enum logic {IDLE, RUN} state_t;

   function automatic int dim_bits(input int max_width);
      return $clog2(max_width + 1);
   endfunction

   function automatic int addr_bits(input int depth);
      return depth > 1 ? $clog2(depth) : 1;
   endfunction

   // line memory that feeds tap j (tap K-1 is the live pixel, tap K-2 the newest memory)
   function automatic int tap_mem(input int k, input int j);
      return k - 2 - j;
   endfunction

   // first image row at which tap j carries real data rather than top padding
   function automatic int tap_first_row(input int k, input int j);
      return k - 1 - j;
   endfunction

endpackage

// File: rtl/wlb_line_mem.sv
// wlb_line_mem: one MAX_WIDTH-deep line store, read returns pre-write contents at addr
// Ports: clk; we write enable; addr column (driven from a register in the parent);
//   wdata new value for addr; rdata current (pre-write) contents of addr.
module wlb_line_mem #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 32,
   parameter int ADDR_BITS  = 5
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_BITS-1:0]  addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   assign rdata = mem[addr];

   always_ff @(posedge clk)
      if (we) mem[addr] <= wdata;

endmodule

// File: rtl/window_line_buffer.sv
// window_line_buffer: K-row line buffer presenting a Kx1 tap column per accepted raster pixel
// Ports: clk; rst async active-high; start latches cfg_width/cfg_height and begins a frame;
//   in_valid/in_data raster pixel stream; out_valid/col_out registered column (slice 0 oldest
//   row, slice K-1 current pixel); out_full all taps real; out_col/out_row current-tap position;
//   frame_done pulse with last output; busy frame in progress; cfg_err sticky illegal config.
// Option: define WLB_CFG_CHECK_EN to reject illegal configs and flag cfg_err instead of clamping.
module window_line_buffer
   import wlb_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_WIDTH  = 32,
   parameter int K          = 5,
   parameter int DIM_BITS   = dim_bits(MAX_WIDTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [DIM_BITS-1:0]     cfg_width,
   input  logic [DIM_BITS-1:0]     cfg_height,
   input  logic                    in_valid,
   input  logic [DATA_WIDTH-1:0]   in_data,
   output logic                    out_valid,
   output logic [K*DATA_WIDTH-1:0] col_out,
   output logic                    out_full,
   output logic [DIM_BITS-1:0]     out_col,
   output logic [DIM_BITS-1:0]     out_row,
   output logic                    frame_done,
   output logic                    busy,
   output logic                    cfg_err
);

   localparam int ADDR_BITS = addr_bits(MAX_WIDTH);
   localparam logic [DIM_BITS-1:0] MAX_W = DIM_BITS'(MAX_WIDTH);

   state_t state, state_nx;
   logic [DIM_BITS-1:0] col, row, width_q, height_q, width_c, height_c;
   logic cfg_ok, last_px, accept;
   logic [DATA_WIDTH-1:0] tap [K];
   logic [DATA_WIDTH-1:0] mem_rd [K-1];
   logic [DATA_WIDTH-1:0] mem_wd [K-1];

   assign width_c  = (cfg_width == '0 || cfg_width > MAX_W) ? MAX_W : cfg_width;
   assign height_c = cfg_height == '0 ? DIM_BITS'(1) : cfg_height;
`ifdef WLB_CFG_CHECK_EN
   assign cfg_ok = cfg_width != '0 && cfg_width <= MAX_W && cfg_height != '0;
`else
   assign cfg_ok = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nx;

   always_comb begin
      state_nx = state;
      if (start) state_nx = cfg_ok ? RUN : IDLE;
      else if (accept && last_px) state_nx = IDLE;
   end

   // a start drops a coincident pixel, except the frame's final pixel so that frame still completes
   always_comb begin
      last_px = col == width_q - DIM_BITS'(1) && row == height_q - DIM_BITS'(1);
      accept  = state == RUN && in_valid && (!start || last_px);
   end

   assign tap[K-1] = in_data;

   for (genvar j = 0; j < K-1; j++) begin : g_mem
      if (j == 0) begin : g_head
         assign mem_wd[j] = in_data;
      end else begin : g_link
         assign mem_wd[j] = mem_rd[j-1];
      end
      assign tap[j] = mem_rd[tap_mem(K, j)];
      wlb_line_mem #(
         .DATA_WIDTH(DATA_WIDTH),
         .DEPTH     (MAX_WIDTH),
         .ADDR_BITS (ADDR_BITS)
      ) u_mem (
         .clk  (clk),
         .we   (accept),
         .addr (col[ADDR_BITS-1:0]),
         .wdata(mem_wd[j]),
         .rdata(mem_rd[j])
      );
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         col        <= '0;
         row        <= '0;
         width_q    <= '0;
         height_q   <= '0;
         out_valid  <= 1'b0;
         col_out    <= '0;
         out_full   <= 1'b0;
         out_col    <= '0;
         out_row    <= '0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         out_valid  <= accept;
         frame_done <= accept && last_px;
         busy       <= state_nx == RUN || (accept && last_px);
         if (accept) begin
            out_col  <= col;
            out_row  <= row;
            out_full <= row >= DIM_BITS'(K-1);
            // padding masks taps whose source row lies above the image, hiding stale memory
            for (int j = 0; j < K; j++)
               col_out[j*DATA_WIDTH +: DATA_WIDTH] <= row >= DIM_BITS'(tap_first_row(K, j)) ? tap[j] : '0;
            col <= col == width_q - DIM_BITS'(1) ? '0 : col + DIM_BITS'(1);
            row <= col == width_q - DIM_BITS'(1) ? row + DIM_BITS'(1) : row;
         end
         if (start) begin
            width_q  <= width_c;
            height_q <= height_c;
            col      <= '0;
            row      <= '0;
         end
      end

`ifdef WLB_CFG_CHECK_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) cfg_err <= 1'b0;
      else if (start && !cfg_ok) cfg_err <= 1'b1;
`else
   assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_window_line_buffer.sv
// tb_window_line_buffer: scoreboard bench for window_line_buffer (K=5, MAX_WIDTH=32, DATA_WIDTH=8)
module tb_window_line_buffer;

   localparam int DW = 8;
   localparam int MW = 32;
   localparam int K  = 5;
   localparam int DB = $clog2(MW + 1);
   localparam int TW = K * DW;

   typedef struct {
      logic [TW-1:0] taps;
      int r;
      int c;
      bit full;
      bit done;
      int cyc;
   } exp_t;

   logic clk = 0, rst = 1, start = 0, in_valid = 0;
   logic [DB-1:0] cfg_width = '0, cfg_height = '0;
   logic [DW-1:0] in_data = '0;
   logic out_valid, out_full, frame_done, busy, cfg_err;
   logic [TW-1:0] col_out;
   logic [DB-1:0] out_col, out_row;

   int n_vec = 0, n_err = 0, n_pulse = 0, cyc = 0;
   int m_w, m_h, m_r, m_c;
   exp_t sb[$];

   window_line_buffer #(.DATA_WIDTH(DW), .MAX_WIDTH(MW), .K(K)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
      .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid), .col_out(col_out),
      .out_full(out_full), .out_col(out_col), .out_row(out_row), .frame_done(frame_done),
      .busy(busy), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] pix(input int r, input int c);
      return DW'((10 * r + c) & 255);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int w, input int h);
      start = 1; cfg_width = DB'(w); cfg_height = DB'(h);
      m_w = (w == 0 || w > MW) ? MW : w;
      m_h = h == 0 ? 1 : h;
      m_r = 0; m_c = 0;
   endtask

   task automatic push_px();
      exp_t e;
      logic [TW-1:0] t;
      for (int j = 0; j < K; j++)
         t[j*DW +: DW] = (m_r >= K-1-j) ? pix(m_r - (K-1-j), m_c) : '0;
      e.taps = t; e.r = m_r; e.c = m_c; e.full = m_r >= K-1;
      e.done = m_r == m_h-1 && m_c == m_w-1; e.cyc = cyc;
      sb.push_back(e);
      in_data = pix(m_r, m_c);
      if (m_c == m_w-1) begin m_c = 0; m_r++; end else m_c++;
   endtask

   task automatic run_px(input int n, input bit stall);
      for (int i = 0; i < n; i++) begin
         if (stall) begin in_valid = 0; step(); end
         in_valid = 1;
         push_px();
         step();
      end
      in_valid = 0;
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (frame_done && !out_valid) check("done_stray", 1, 0);
      if (out_valid) begin
         n_pulse++;
         if (sb.size() == 0) check("extra_valid", 1, 0);
         else begin
            e = sb.pop_front();
            check("taps", col_out, e.taps);
            check("out_col", out_col, e.c);
            check("out_row", out_row, e.r);
            check("out_full", out_full, e.full);
            check("frame_done", frame_done, e.done);
            check("latency", cyc, e.cyc + 1);
         end
      end
   end

   initial begin
      int p0;
      step(); step();
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_cols", col_out, 0);
      check("rst_done", frame_done, 0);
      check("rst_full", out_full, 0);
      check("rst_err", cfg_err, 0);
      rst = 0;
      step();

      // reset mid-frame
      do_start(5, 5); step(); start = 0;
      run_px(7, 0);
      step();
      check("pre_rst_busy", busy, 1);
      rst = 1; #1;
      check("mid_rst_cols", col_out, 0);
      check("mid_rst_col", out_col, 0);
      check("mid_rst_row", out_row, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_valid", out_valid, 0);
      step(); rst = 0; step();

      // 5x5 continuous
      p0 = n_pulse;
      do_start(5, 5); step(); start = 0;
      check("busy_run", busy, 1);
      run_px(25, 0);
      check("end_done", frame_done, 1);
      check("end_busy", busy, 1);
      check("end_taps", col_out, {8'd44, 8'd34, 8'd24, 8'd14, 8'd4});
      step();
      check("post_busy", busy, 0);
      check("post_done", frame_done, 0);
      check("pulses_5x5", n_pulse - p0, 25);

      // 28x28 with in_valid toggling
      p0 = n_pulse;
      do_start(28, 28); step(); start = 0;
      run_px(784, 1);
      step(); step();
      check("pulses_28", n_pulse - p0, 784);

      // abort at row 2 of a 14-wide frame, start coincides with a valid pixel
      do_start(14, 5); step(); start = 0;
      run_px(33, 0);
      do_start(14, 5); in_valid = 1; in_data = 8'hff; step(); start = 0; in_valid = 0;
      run_px(70, 0);
      step(); step();

`ifdef WLB_CFG_CHECK_EN
      do_start(40, 2); step(); start = 0;
      check("cfg_err_set", cfg_err, 1);
      check("cfg_err_busy", busy, 0);
      in_valid = 1; step(); step(); in_valid = 0;
      do_start(3, 2); step(); start = 0;
      run_px(6, 0);
      step();
      check("cfg_err_sticky", cfg_err, 1);
`else
      // width 40 clamps to 32; restart coincides with the final accept
      do_start(40, 2); step(); start = 0;
      run_px(63, 0);
      in_valid = 1; push_px(); do_start(3, 2); step(); start = 0; in_valid = 0;
      check("restart_done", frame_done, 1);
      step();
      check("restart_busy", busy, 1);
      run_px(6, 0);
      step();
      check("no_cfg_err", cfg_err, 0);
      // zero config clamps to 32x1
      do_start(0, 0); step(); start = 0;
      run_px(32, 0);
      step();
`endif
      step(); step();
      check("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
